// File: rtl/rvee_mem_stage.sv
// rvee_mem_stage: RISC-V memory stage between exec and writeback.
// Non-memory ops pass through in one cycle. Aligned loads and stores run on a
// req/gnt/rvalid bus. Misaligned accesses, bus errors and bus timeouts raise
// an exception pulse. All writeback and exception outputs are registered.
module rvee_mem_stage #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]   in_result,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_be,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_err,
    output logic [4:0]        rd,
    output logic              rd_we,
    output logic [XLEN-1:0]   rd_data,
    output logic              exception,
    output logic [XLEN-1:0]   fault_pc,
    output logic [XLEN-1:0]   fault_addr,
    output logic [XLEN-2:0]   n_cause
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // Exception cause code: access selects fault (5/7) over misaligned (4/6).
    function automatic logic [XLEN-2:0] cause_code(input logic is_store, input logic access);
        logic [2:0] code;
        code = access ? (is_store ? 3'd7 : 3'd5) : (is_store ? 3'd6 : 3'd4);
        return {{(XLEN-4){1'b0}}, code};
    endfunction

    // Natural-alignment check; a dword access is never legal on a 32-bit datapath.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return low[0];
            2'd2:    return |low[1:0];
            2'd3:    return (XLEN == 32) || (|low);
            default: return 1'b0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   pc_q, pc_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              store_q, store_d, uns_q, uns_d, lrdwe_q, lrdwe_d;
    logic [1:0]        size_q, size_d;
    logic [4:0]        lrd_q, lrd_d, rd_q, rd_d;
    logic              rd_we_q, rd_we_d, exc_q, exc_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d, fpc_q, fpc_d, faddr_q, faddr_d;
    logic [XLEN-2:0]   cause_q, cause_d;

    logic [BE_W-1:0]   be_base_s;
    logic [XLEN-1:0]   rdata_sh_s, lmask_s, load_val_s;
    logic              sign_s, timeout_s;

    // Lane placement for a new access and sub-word extraction for the response.
    assign be_base_s  = BE_W'((32'd1 << (32'd1 << in_size)) - 32'd1);
    assign rdata_sh_s = bus_rdata >> {addr_q[OFF_W-1:0], 3'b000};
    assign lmask_s    = (XLEN'(1'b1) << (32'd8 << size_q)) - XLEN'(1'b1);
    assign load_val_s = (rdata_sh_s & lmask_s) | ((!uns_q && sign_s) ? ~lmask_s : {XLEN{1'b0}});
    assign timeout_s  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Sign bit of the loaded sub-word.
    always_comb begin
        sign_s = 1'b0;
        case (size_q)
            2'd0:    sign_s = rdata_sh_s[7];
            2'd1:    sign_s = rdata_sh_s[15];
            2'd2:    sign_s = rdata_sh_s[31];
            default: sign_s = rdata_sh_s[XLEN-1];
        endcase
    end

    // Next-state and output computation for the IDLE/REQ/WAIT controller.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        store_d   = store_q;
        size_d    = size_q;
        uns_d     = uns_q;
        lrd_d     = lrd_q;
        lrdwe_d   = lrdwe_q;
        rd_d      = rd_q;
        rd_data_d = rd_data_q;
        rd_we_d   = 1'b0;
        exc_d     = 1'b0;
        fpc_d     = fpc_q;
        faddr_d   = faddr_q;
        cause_d   = cause_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!in_load && !in_store) begin
                        rd_d      = in_rd;
                        rd_data_d = in_result;
                        rd_we_d   = in_rd_we && (in_rd != 5'd0);
                    end else if (is_misaligned(in_size, in_addr[2:0])) begin
                        exc_d   = 1'b1;
                        fpc_d   = in_pc;
                        faddr_d = in_addr;
                        cause_d = cause_code(in_store, 1'b0);
                    end else begin
                        pc_d    = in_pc;
                        addr_d  = in_addr;
                        wdata_d = in_wdata << {in_addr[OFF_W-1:0], 3'b000};
                        be_d    = be_base_s << in_addr[OFF_W-1:0];
                        store_d = in_store;
                        size_d  = in_size;
                        uns_d   = in_unsigned;
                        lrd_d   = in_rd;
                        lrdwe_d = in_rd_we;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1'b1);
                if (timeout_s) begin
                    exc_d   = 1'b1;
                    fpc_d   = pc_q;
                    faddr_d = addr_q;
                    cause_d = cause_code(store_q, 1'b1);
                    state_d = S_IDLE;
                end else if (bus_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1'b1);
                // A response in the timeout cycle still completes the access.
                if (bus_rvalid) begin
                    state_d = S_IDLE;
                    if (bus_err) begin
                        exc_d   = 1'b1;
                        fpc_d   = pc_q;
                        faddr_d = addr_q;
                        cause_d = cause_code(store_q, 1'b1);
                    end else if (!store_q) begin
                        rd_d      = lrd_q;
                        rd_data_d = load_val_s;
                        rd_we_d   = lrdwe_q && (lrd_q != 5'd0);
                    end else begin
                        rd_we_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    exc_d   = 1'b1;
                    fpc_d   = pc_q;
                    faddr_d = addr_q;
                    cause_d = cause_code(store_q, 1'b1);
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched op and registered outputs; reset returns to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            pc_q      <= {XLEN{1'b0}};
            addr_q    <= {XLEN{1'b0}};
            wdata_q   <= {XLEN{1'b0}};
            be_q      <= {BE_W{1'b0}};
            store_q   <= 1'b0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            lrd_q     <= 5'd0;
            lrdwe_q   <= 1'b0;
            rd_q      <= 5'd0;
            rd_data_q <= {XLEN{1'b0}};
            rd_we_q   <= 1'b0;
            exc_q     <= 1'b0;
            fpc_q     <= {XLEN{1'b0}};
            faddr_q   <= {XLEN{1'b0}};
            cause_q   <= {(XLEN-1){1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            store_q   <= store_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            lrd_q     <= lrd_d;
            lrdwe_q   <= lrdwe_d;
            rd_q      <= rd_d;
            rd_data_q <= rd_data_d;
            rd_we_q   <= rd_we_d;
            exc_q     <= exc_d;
            fpc_q     <= fpc_d;
            faddr_q   <= faddr_d;
            cause_q   <= cause_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign bus_req    = (state_q == S_REQ);
    assign bus_we     = store_q;
    assign bus_addr   = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign bus_wdata  = wdata_q;
    assign bus_be     = be_q;
    assign rd         = rd_q;
    assign rd_we      = rd_we_q;
    assign rd_data    = rd_data_q;
    assign exception  = exc_q;
    assign fault_pc   = fpc_q;
    assign fault_addr = faddr_q;
    assign n_cause    = cause_q;
endmodule
